mem_ctrl: RTL
=============

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter: DATA_WID, default 32, data and address width.
REQ-002 Parameter: ADDR_LIMIT, default 10, highest legal word address; must equal data-memory depth.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 req_valid  input  1  execute stage presents a memory request.
REQ-006 req_ready  output  1  controller can accept a request this cycle.
REQ-007 req_read  input  1  request is a load.
REQ-008 req_write  input  1  request is a store.
REQ-009 req_addr  input  DATA_WID  word address (valE).
REQ-010 req_data  input  DATA_WID  store data (valA).
REQ-011 mem_addr  output  DATA_WID  address to data memory.
REQ-012 mem_wdata  output  DATA_WID  write data to data memory.
REQ-013 mem_read_flag  output  1  read strobe to data memory.
REQ-014 mem_write_flag  output  1  write strobe to data memory.
REQ-015 mem_valM  input  DATA_WID  combinational read data from data memory.
REQ-016 mem_error  input  1  data-memory address error.
REQ-017 resp_valid  output  1  response available to write-back stage.
REQ-018 resp_ready  input  1  write-back stage accepts response.
REQ-019 resp_valM  output  DATA_WID  loaded value; 0 for stores, no-ops, errors.
REQ-020 resp_stat  output  2  00 AOK, 01 ADR, 10 INS (read and write both set).
REQ-021 halted  output  1  sticky flag, set by first non-AOK response.

Function
REQ-022 States IDLE, ACCESS, RESP; one-hot or binary encoding, implementer's choice.
REQ-023 IDLE: req_ready=1, all other outputs at reset values; req_valid&&req_ready at edge N captures read, write, addr, data into registers and moves to ACCESS.
REQ-024 ACCESS lasts exactly one cycle (N+1): mem_addr/mem_wdata driven from captured registers; at end of cycle stat and valM registered, state -> RESP.
REQ-025 Range check internal: addr_bad = captured addr > ADDR_LIMIT (unsigned); strobes derive only from registered values, never from mem_error (no combinational loop).
REQ-026 In ACCESS: mem_read_flag = read&&!write&&!addr_bad&&!halted; mem_write_flag = write&&!read&&!addr_bad&&!halted; strobes 0 in all other states.
REQ-027 Stat priority: read&&write -> INS; else (read||write)&&(addr_bad||mem_error) -> ADR; else AOK; neither flag -> AOK no-op.
REQ-028 resp_valM = mem_valM sampled at end of ACCESS for AOK reads, else 0.
REQ-029 RESP (cycle N+2 onward): resp_valid=1, resp_valM/resp_stat stable until resp_ready; on resp_valid&&resp_ready -> IDLE; no new request accepted same cycle (req_ready=0 in ACCESS and RESP).
REQ-030 Throughput: one request per 3 cycles with resp_ready held high; backpressure stalls in RESP indefinitely.
REQ-031 halted set at the edge leaving ACCESS with non-AOK stat; once set, every later request completes with no strobes, resp_valM=0, resp_stat=ADR (INS if read&&write).
REQ-032 ADDR_LIMIT itself is legal; ADDR_LIMIT+1 and values with upper bits set (e.g. 0xFFFFFFFF) are ADR.

Reset
REQ-033 rst high at a clock edge forces IDLE, halted=0, captured registers=0, resp_valM=0, resp_stat=00, resp_valid=0, strobes=0, regardless of state (including mid-ACCESS or pending RESP; pending response discarded, no write issued after the reset edge).
REQ-034 rst has priority over req_valid in the same cycle; req_ready=1 first cycle after rst deasserts.

Verification
REQ-035 Store addr 3 data 0x0000_00AB, then load addr 3 -> write strobe one cycle in ACCESS, load responds resp_valM=0xAB, stat 00, resp_valid two cycles after acceptance.
REQ-036 Load addr 11 (ADDR_LIMIT=10) -> no strobes, resp_stat=01, resp_valM=0, halted=1; next store addr 2 -> no write strobe, stat 01.
REQ-037 Request read=1 write=1 addr 4 -> no strobes, resp_stat=10, halted=1.
REQ-038 Load addr 10 with resp_ready low 5 cycles -> resp_valid and data held 5 cycles, req_ready=0 throughout, IDLE one cycle after handshake.
REQ-039 rst asserted during ACCESS of a store to addr 5 -> at most the pre-reset ACCESS-cycle strobe, none after; outputs at reset values next cycle; halted=0.
REQ-040 Back-to-back loads with resp_ready=1 -> accepted every 3rd cycle, no overlap of strobes.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: three-state (IDLE/ACCESS/RESP) data-memory controller between execute and write-back.
// Captures one request, issues a single-cycle memory access, holds the response until accepted.
module mem_ctrl #(
    parameter int DATA_WID   = 32,
    parameter int ADDR_LIMIT = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_read,
    input  logic                req_write,
    input  logic [DATA_WID-1:0] req_addr,
    input  logic [DATA_WID-1:0] req_data,
    output logic [DATA_WID-1:0] mem_addr,
    output logic [DATA_WID-1:0] mem_wdata,
    output logic                mem_read_flag,
    output logic                mem_write_flag,
    input  logic [DATA_WID-1:0] mem_valM,
    input  logic                mem_error,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_WID-1:0] resp_valM,
    output logic [1:0]          resp_stat,
    output logic                halted
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam logic [1:0] AOK = 2'b00, ADR = 2'b01, INS = 2'b10;
    localparam logic [DATA_WID-1:0] LIMIT = DATA_WID'(ADDR_LIMIT);
    state_t              r_state;
    logic                r_read, r_write, r_halted;
    logic [DATA_WID-1:0] r_addr, r_data, r_valM;
    logic [1:0]          r_stat;
    logic                w_access, w_addr_bad;
    logic [1:0]          w_stat;
    assign w_access   = r_state == ACCESS;
    assign w_addr_bad = r_addr > LIMIT;
    // once halted, every request reports ADR unless it is the illegal read+write combination
    assign w_stat = (r_read && r_write) ? INS :
                    (r_halted || ((r_read || r_write) && (w_addr_bad || mem_error))) ? ADR : AOK;
    assign req_ready      = r_state == IDLE;
    assign resp_valid     = r_state == RESP;
    assign mem_addr       = w_access ? r_addr : '0;
    assign mem_wdata      = w_access ? r_data : '0;
    assign mem_read_flag  = w_access && r_read && !r_write && !w_addr_bad && !r_halted;
    assign mem_write_flag = w_access && r_write && !r_read && !w_addr_bad && !r_halted;
    assign resp_valM      = r_valM;
    assign resp_stat      = r_stat;
    assign halted         = r_halted;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_read   <= 1'b0;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_valM   <= '0;
            r_stat   <= AOK;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (req_valid) begin
                    r_read  <= req_read;
                    r_write <= req_write;
                    r_addr  <= req_addr;
                    r_data  <= req_data;
                    r_state <= ACCESS;
                end
                ACCESS: begin
                    r_stat   <= w_stat;
                    r_valM   <= (w_stat == AOK && r_read) ? mem_valM : '0;
                    r_halted <= r_halted || (w_stat != AOK);
                    r_state  <= RESP;
                end
                RESP: if (resp_ready) begin
                    r_valM  <= '0;
                    r_stat  <= AOK;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
